// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller, ALU decoder and datapath.
// The same constants drive the datapath muxes and the ALU.
package mips_mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIWB = 4'd9,
      S_JUMP   = 4'd10,
      S_ERR    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // States that stall on mem_ready and are guarded by the wait counter.
   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mips_mc_ctrl_if;
   import mips_mc_ctrl_pkg::*;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;

   logic       pc_we, iord, mem_rd, mem_wr, ir_we;
   logic       reg_dst, mem_to_reg, reg_we, alu_src_a, fault;
   logic [1:0] pc_src;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctrl;
   logic [3:0] state;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we,
             alu_src_a, fault, pc_src, alu_src_b, alu_ctrl, state
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we,
             alu_src_a, fault, pc_src, alu_src_b, alu_ctrl, state
   );
endinterface

// File: rtl/mips_mc_ctrl_alu_dec.sv
// R-type funct -> ALU operation. Unknown functs report illegal and yield code 000.
module mips_alu_dec
   import mips_mc_ctrl_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_ctrl,
   output logic       o_legal
);
   always_comb begin
      o_alu_ctrl = ALU_AND;
      o_legal    = 1'b1;
      case (i_funct)
         FN_ADD:  o_alu_ctrl = ALU_ADD;
         FN_SUB:  o_alu_ctrl = ALU_SUB;
         FN_AND:  o_alu_ctrl = ALU_AND;
         FN_OR:   o_alu_ctrl = ALU_OR;
         FN_SLT:  o_alu_ctrl = ALU_SLT;
         default: o_legal    = 1'b0;
      endcase
   end
endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM (Moore) with memory-wait timeout and sticky fault state.
module mips_mc_ctrl
   import mips_mc_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mips_mc_ctrl_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_wait_cnt;
   logic            w_wait_expired;
   logic [2:0]      w_fn_alu;
   logic            w_fn_legal;

   mips_alu_dec u_alu_dec (
      .i_funct    (bus.funct),
      .o_alu_ctrl (w_fn_alu),
      .o_legal    (w_fn_legal)
   );

   assign w_wait_expired = (r_wait_cnt == CW'(TIMEOUT - 1));
   assign bus.state      = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Any state change (including entry to a wait state) or a ready pulse restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_wait_cnt <= '0;
      else if ((w_next != r_state) || bus.mem_ready)
         r_wait_cnt <= '0;
      else if (is_wait_state(r_state))
         r_wait_cnt <= r_wait_cnt + 1'b1;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH, S_MEMRD, S_MEMWR: begin
            if (bus.mem_ready) begin
               case (r_state)
                  S_FETCH: w_next = S_DECODE;
                  S_MEMRD: w_next = S_MEMWB;
                  default: w_next = S_FETCH;
               endcase
            end else if (w_wait_expired) begin
               w_next = S_ERR;
            end
         end
         S_DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW, OP_ADDI: w_next = S_MEMADR;
               OP_RTYPE:              w_next = S_EXEC;
               OP_BEQ:                w_next = S_BRANCH;
               OP_J:                  w_next = S_JUMP;
               default:               w_next = S_ERR;
            endcase
         end
         S_MEMADR: begin
            case (bus.opcode)
               OP_LW:   w_next = S_MEMRD;
               OP_SW:   w_next = S_MEMWR;
               OP_ADDI: w_next = S_ADDIWB;
               default: w_next = S_ERR;
            endcase
         end
         S_EXEC:   w_next = w_fn_legal ? S_ALUWB : S_ERR;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_ERR;
      endcase
   end

   always_comb begin
      bus.pc_we      = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.ir_we      = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_we     = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.fault      = 1'b0;
      bus.pc_src     = PC_ALU;
      bus.alu_src_b  = SRCB_B;
      bus.alu_ctrl   = ALU_AND;
      case (r_state)
         S_FETCH: begin
            // rst_n gate keeps PC/IR frozen while reset is held.
            bus.mem_rd    = 1'b1;
            bus.alu_src_b = SRCB_FOUR;
            bus.alu_ctrl  = ALU_ADD;
            bus.pc_we     = bus.mem_ready & rst_n;
            bus.ir_we     = bus.mem_ready & rst_n;
         end
         S_DECODE: begin
            bus.alu_src_b = SRCB_IMMSH;
            bus.alu_ctrl  = ALU_ADD;
         end
         S_MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_ctrl  = ALU_ADD;
         end
         S_MEMRD: begin
            bus.mem_rd = 1'b1;
            bus.iord   = 1'b1;
         end
         S_MEMWB: begin
            bus.reg_we     = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_wr = 1'b1;
            bus.iord   = 1'b1;
         end
         S_EXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_ctrl  = w_fn_alu;
         end
         S_ALUWB: begin
            bus.reg_we  = 1'b1;
            bus.reg_dst = 1'b1;
         end
         S_ADDIWB: bus.reg_we = 1'b1;
         S_BRANCH: begin
            bus.alu_src_a = 1'b1;
            bus.alu_ctrl  = ALU_SUB;
            bus.pc_src    = PC_ALUOUT;
            bus.pc_we     = bus.zero;
         end
         S_JUMP: begin
            bus.pc_src = PC_JUMP;
            bus.pc_we  = 1'b1;
         end
         S_ERR:   bus.fault = 1'b1;
         default: bus.fault = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboarded bench for mips_mc_ctrl: expected state/outputs queued per cycle, checked at negedge.
module tb_mips_mc_ctrl;
   import mips_mc_ctrl_pkg::*;

   typedef struct packed {
      logic [3:0]  st;
      logic [16:0] ov;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   mips_mc_ctrl_if bus ();

   mips_mc_ctrl #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [16:0] dut_ov;
   assign dut_ov = {bus.pc_we, bus.iord, bus.mem_rd, bus.mem_wr, bus.ir_we, bus.reg_dst,
                    bus.mem_to_reg, bus.reg_we, bus.alu_src_a, bus.fault,
                    bus.pc_src, bus.alu_src_b, bus.alu_ctrl};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Output decode table written from the state descriptions.
   function automatic logic [16:0] mdl(logic [3:0] st, logic rdy, logic z, logic [5:0] fn, logic rst);
      logic pw, io, rd, wr, iw, rdst, m2r, rwe, sa, flt;
      logic [1:0] ps, sb_;
      logic [2:0] al;
      {pw, io, rd, wr, iw, rdst, m2r, rwe, sa, flt} = '0;
      ps = 2'b00; sb_ = 2'b00; al = 3'b000;
      case (st)
         4'd0:  begin rd = 1; sb_ = 2'b01; al = 3'b010; pw = rdy & rst; iw = rdy & rst; end
         4'd1:  begin sb_ = 2'b11; al = 3'b010; end
         4'd2:  begin sa = 1; sb_ = 2'b10; al = 3'b010; end
         4'd3:  begin rd = 1; io = 1; end
         4'd4:  begin rwe = 1; m2r = 1; end
         4'd5:  begin wr = 1; io = 1; end
         4'd6: begin
            sa = 1;
            case (fn)
               6'h20: al = 3'b010;
               6'h22: al = 3'b110;
               6'h24: al = 3'b000;
               6'h25: al = 3'b001;
               6'h2A: al = 3'b111;
               default: al = 3'b000;
            endcase
         end
         4'd7:  begin rwe = 1; rdst = 1; end
         4'd8:  begin sa = 1; al = 3'b110; ps = 2'b01; pw = z; end
         4'd9:  rwe = 1;
         4'd10: begin ps = 2'b10; pw = 1; end
         default: flt = 1;
      endcase
      return {pw, io, rd, wr, iw, rdst, m2r, rwe, sa, flt, ps, sb_, al};
   endfunction

   // Queue the expectation for the current cycle, then compare at the falling edge.
   task automatic step(input logic [3:0] es);
      exp_t e;
      e.st = es;
      e.ov = mdl(es, bus.mem_ready, bus.zero, bus.funct, rst_n);
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = sb.pop_front();
         chk("state", bus.state, e.st);
         chk("outputs", dut_ov, e.ov);
         chk("rd_wr_excl", bus.mem_rd & bus.mem_wr, 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(4'd0);
      rst_n = 1'b1;
   endtask

   logic [5:0] fns [5];

   initial begin
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      bus.opcode    = 6'h00;
      bus.funct     = 6'h20;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;

      // Reset: FETCH decode but no PC/IR write even with mem_ready high.
      step(4'd0);
      step(4'd0);
      rst_n = 1'b1;

      // lw, zero wait
      bus.opcode = 6'h23;
      step(4'd0); step(4'd1); step(4'd2); step(4'd3); step(4'd4);

      // beq not taken, then taken
      bus.opcode = 6'h04;
      bus.zero = 1'b0;
      step(4'd0); step(4'd1); step(4'd8);
      bus.zero = 1'b1;
      step(4'd0); step(4'd1); step(4'd8);
      bus.zero = 1'b0;

      // sw with 3 wait cycles in MEMWR
      bus.opcode = 6'h2B;
      step(4'd0); step(4'd1); step(4'd2);
      bus.mem_ready = 1'b0;
      step(4'd5); step(4'd5); step(4'd5);
      bus.mem_ready = 1'b1;
      step(4'd5);

      // every legal R-type funct
      bus.opcode = 6'h00;
      foreach (fns[i]) begin
         bus.funct = fns[i];
         step(4'd0); step(4'd1); step(4'd6); step(4'd7);
      end

      // addi; mem_ready low outside memory states must be ignored
      bus.opcode = 6'h08;
      step(4'd0);
      bus.mem_ready = 1'b0;
      step(4'd1); step(4'd2); step(4'd9);

      // j, preceded by 15 waiting cycles in FETCH (one short of timeout)
      bus.opcode = 6'h02;
      repeat (15) step(4'd0);
      bus.mem_ready = 1'b1;
      step(4'd0); step(4'd1); step(4'd10);

      // FETCH timeout: 16 waiting cycles then sticky ERR
      bus.mem_ready = 1'b0;
      repeat (16) step(4'd0);
      step(4'd15);
      bus.mem_ready = 1'b1;
      step(4'd15); step(4'd15);
      do_reset();

      // illegal opcode
      bus.opcode = 6'h3F;
      step(4'd0); step(4'd1); step(4'd15); step(4'd15);
      do_reset();

      // illegal funct
      bus.opcode = 6'h00;
      bus.funct  = 6'h01;
      step(4'd0); step(4'd1); step(4'd6); step(4'd15);
      do_reset();

      // asynchronous reset in the middle of a store
      bus.opcode = 6'h2B;
      bus.funct  = 6'h20;
      step(4'd0); step(4'd1); step(4'd2);
      bus.mem_ready = 1'b0;
      step(4'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_state", bus.state, 4'd0);
      chk("async_rst_mem_wr", bus.mem_wr, 1'b0);
      chk("async_rst_fault", bus.fault, 1'b0);
      chk("async_rst_reg_we", bus.reg_we, 1'b0);
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      step(4'd0);
      rst_n = 1'b1;
      bus.opcode = 6'h02;
      step(4'd0); step(4'd1); step(4'd10); step(4'd0);

      if (sb.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL scoreboard_leftover %0d entries", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mc_ctrl.md
MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles any memory state waits for mem_ready before fault.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  IR[31:26] from the instruction register.
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory done; read data valid or write accepted this cycle.
REQ-008 Outputs, 1 bit each: pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we, alu_src_a, fault.
REQ-009 Outputs, multi-bit: pc_src 2 (00 ALU, 01 ALUOut, 10 jump target); alu_src_b 2 (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2); alu_ctrl 3 (010 add, 110 sub, 000 and, 001 or, 111 slt); state 4 (debug).

Function
REQ-010 Moore FSM; outputs decode from state register, plus mem_ready/zero qualifiers.
REQ-011 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIWB 9, JUMP 10, ERR 15.
REQ-012 FETCH: mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00; pc_we=ir_we=mem_ready; to DECODE on mem_ready, else hold.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add; next by opcode: 0x23/0x2B/0x08 -> MEMADR, 0x00 -> EXEC, 0x04 -> BRANCH, 0x02 -> JUMP, other -> ERR.
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10, add; next MEMRD (lw), MEMWR (sw), ADDIWB (addi).
REQ-015 MEMRD: mem_rd=1, iord=1; to MEMWB on mem_ready. MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; to FETCH.
REQ-016 MEMWR: mem_wr=1, iord=1; to FETCH on mem_ready.
REQ-017 EXEC: alu_src_a=1, alu_src_b=00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt; other funct -> ERR; else to ALUWB. ALUWB: reg_we=1, reg_dst=1, mem_to_reg=0; to FETCH.
REQ-018 ADDIWB: reg_we=1, reg_dst=0, mem_to_reg=0; to FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_we=zero; to FETCH.
REQ-020 JUMP: pc_src=10, pc_we=1; to FETCH.
REQ-021 Unlisted outputs are 0 in each state; mem_rd and mem_wr never both 1.
REQ-022 Zero-wait cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-023 Wait counter: clears on entry to FETCH/MEMRD/MEMWR and on mem_ready; increments each waiting cycle; reaching TIMEOUT -> ERR.
REQ-024 ERR: fault=1, all other outputs 0; sticky until reset.
REQ-025 mem_ready outside FETCH/MEMRD/MEMWR ignored.

Reset
REQ-026 rst_n low asynchronously forces state=FETCH, wait counter=0, fault=0; mid-instruction reset abandons the instruction with no further pc_we/reg_we/mem_wr.
REQ-027 While in reset, outputs show FETCH decode with pc_we=ir_we=0 regardless of mem_ready.

Structure
REQ-028 Shared package holds state encodings, opcode/funct constants, alu_ctrl and pc_src/alu_src_b codes; the ALU and datapath use the same constants.
REQ-029 One sub-module, mips_alu_dec (funct -> alu_ctrl, plus legal flag), instantiated in EXEC decode.

Verification
REQ-030 lw (0x23), mem_ready tied 1 -> states 0,1,2,3,4,0; reg_we=1 and mem_to_reg=1 only in cycle 5.
REQ-031 beq (0x04), zero=0 then repeat with zero=1 -> pc_we in BRANCH 0 then 1; pc_src=01 both.
REQ-032 sw, mem_ready low 3 cycles in MEMWR -> mem_wr held 4 cycles, then FETCH; no fault.
REQ-033 mem_ready held low in FETCH, TIMEOUT=16 -> ERR after 16 waiting cycles, fault=1 until rst_n low.
REQ-034 opcode 0x3F -> DECODE then ERR; R-type funct 0x01 -> EXEC then ERR.
REQ-035 rst_n low during MEMWR -> state=FETCH immediately (asynchronous), mem_wr=0, fault=0.
